vga_palette_engine: RTL and testbench

VGA_PALETTE_ENGINE -- requirements
Module: vga_palette_engine

---
 rtl/vga_palette_engine_pkg.sv | 30 +++
 rtl/vga_palette_engine_axis.sv | 42 ++++
 rtl/vga_palette_engine.sv | 215 +++++++++++++++++++++
 tb/tb_vga_palette_engine.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_palette_engine_pkg.sv
// Shared constants for the VGA palette engine: command opcodes, display
// modes, FIFO read FSM states and command parser states.
package vga_palette_engine_pkg;

    localparam logic [1:0] OP_SETPAL = 2'b00;
    localparam logic [1:0] OP_MODE   = 2'b01;
    localparam logic [1:0] OP_COMMIT = 2'b10;
    localparam logic [1:0] OP_RSVD   = 2'b11;

    typedef enum logic [1:0] {
        MODE_SOLID = 2'd0,
        MODE_HBAR  = 2'd1,
        MODE_VBAR  = 2'd2,
        MODE_XOR   = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOW,
        ST_RECOVER
    } rd_state_e;

    typedef enum logic [1:0] {
        PS_CMD,
        PS_RED,
        PS_GREEN,
        PS_BLUE
    } parse_e;

endpackage

// File: rtl/vga_palette_engine_axis.sv
// One raster axis: wrapping position counter with sync, visible and
// single-position marker decode. Used once per axis by the top.
module vga_axis_counter #(
    parameter int   VIS  = 800,
    parameter int   FP   = 40,
    parameter int   SYNC = 128,
    parameter int   BP   = 88,
    parameter int   W    = 11,
    parameter int   MARK = 0,
    parameter logic POL  = 1'b1
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         i_en,
    output logic [W-1:0] o_count,
    output logic         o_at_mark,
    output logic         o_sync,
    output logic         o_vis
);
    localparam int           TOTAL   = VIS + FP + SYNC + BP;
    localparam logic [W-1:0] LAST    = W'(TOTAL - 1);
    localparam logic [W-1:0] SYNC_LO = W'(VIS + FP);
    localparam logic [W-1:0] SYNC_HI = W'(VIS + FP + SYNC - 1);
    localparam logic [W-1:0] VIS_END = W'(VIS);
    localparam logic [W-1:0] MARK_AT = W'(MARK);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= (r_count == LAST) ? '0 : r_count + W'(1);
        end
    end

    assign o_count   = r_count;
    assign o_at_mark = (r_count == MARK_AT);
    assign o_sync    = (r_count >= SYNC_LO && r_count <= SYNC_HI) ? POL : ~POL;
    assign o_vis     = (r_count < VIS_END);

endmodule

// File: rtl/vga_palette_engine.sv
// VGA palette engine: raster timing, shadow/active palette with frame-aligned
// commit, and a byte-command parser fed through a slow external FIFO.
module vga_palette_engine
    import vga_palette_engine_pkg::*;
#(
    parameter int   CLK_DIV   = 3,
    parameter int   CW        = 4,
    parameter int   PAL_BITS  = 2,
    parameter int   BAR_SHIFT = 5,
    parameter int   H_VIS     = 800,
    parameter int   H_FP      = 40,
    parameter int   H_SYNC    = 128,
    parameter int   H_BP      = 88,
    parameter int   V_VIS     = 600,
    parameter int   V_FP      = 1,
    parameter int   V_SYNC    = 4,
    parameter int   V_BP      = 23,
    parameter logic HSYNC_POL = 1'b1,
    parameter logic VSYNC_POL = 1'b1,
    parameter int   RD_LOW    = 6,
    parameter int   RD_LATCH  = 5,
    parameter int   RD_HIGH   = 2
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic [7:0]    fifo_data,
    input  logic          fifo_nef,
    output logic          fifo_nrd,
    output logic          hsync,
    output logic          vsync,
    output logic [CW-1:0] red,
    output logic [CW-1:0] green,
    output logic [CW-1:0] blue
);
    localparam int H_TOTAL   = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL   = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int MAX_TOTAL = (H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL;
    localparam int CNT_W     = $clog2(MAX_TOTAL);
    localparam int TICK_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int NENT      = 1 << PAL_BITS;

    logic [TICK_W-1:0]   r_tick;
    logic                w_stb;
    logic [CNT_W-1:0]    w_h, w_v;
    logic                w_hmark, w_vmark, w_hsync, w_vsync, w_hvis, w_vvis;
    logic [CNT_W-1:0]    w_sh_h, w_sh_v, w_sh_x;
    logic [PAL_BITS-1:0] w_idx;
    logic [3*CW-1:0]     w_pix;
    logic                w_cap, w_commit, w_unused;

    rd_state_e           r_state;
    logic [7:0]          r_rdcnt;
    logic                r_nef_sync;

    parse_e              r_pstate;
    logic [PAL_BITS-1:0] r_pidx;
    logic [CW-1:0]       r_red, r_green;
    logic [3*CW-1:0]     r_shadow [NENT];
    logic [3*CW-1:0]     r_active [NENT];
    mode_e               r_shd_mode, r_act_mode;
    logic                r_pending;

    assign w_stb = (r_tick == '0);

    // Horizontal mark sits on the last pixel so it doubles as the line carry.
    vga_axis_counter #(
        .VIS(H_VIS), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP),
        .W(CNT_W), .MARK(H_TOTAL - 1), .POL(HSYNC_POL)
    ) u_hcnt (
        .clk(clk), .nrst(nrst), .i_en(w_stb),
        .o_count(w_h), .o_at_mark(w_hmark), .o_sync(w_hsync), .o_vis(w_hvis)
    );

    vga_axis_counter #(
        .VIS(V_VIS), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP),
        .W(CNT_W), .MARK(V_VIS - 1), .POL(VSYNC_POL)
    ) u_vcnt (
        .clk(clk), .nrst(nrst), .i_en(w_stb & w_hmark),
        .o_count(w_v), .o_at_mark(w_vmark), .o_sync(w_vsync), .o_vis(w_vvis)
    );

    assign w_sh_h = w_h >> BAR_SHIFT;
    assign w_sh_v = w_v >> BAR_SHIFT;
    assign w_sh_x = (w_h ^ w_v) >> BAR_SHIFT;

    always_comb begin
        w_idx = '0;
        case (r_act_mode)
            MODE_SOLID: w_idx = '0;
            MODE_HBAR:  w_idx = w_sh_h[PAL_BITS-1:0];
            MODE_VBAR:  w_idx = w_sh_v[PAL_BITS-1:0];
            MODE_XOR:   w_idx = w_sh_x[PAL_BITS-1:0];
            default:    w_idx = '0;
        endcase
    end

    assign w_pix    = r_active[w_idx];
    assign w_cap    = (r_state == ST_LOW) && (r_rdcnt == 8'(RD_LATCH));
    assign w_commit = w_stb && w_hmark && w_vmark && r_pending;
    assign w_unused = ^{fifo_data, w_sh_h, w_sh_v, w_sh_x};

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_tick <= '0;
            hsync  <= ~HSYNC_POL;
            vsync  <= ~VSYNC_POL;
            red    <= '0;
            green  <= '0;
            blue   <= '0;
        end else begin
            r_tick <= (r_tick == TICK_W'(CLK_DIV - 1)) ? '0 : r_tick + TICK_W'(1);
            if (w_stb) begin
                hsync <= w_hsync;
                vsync <= w_vsync;
                if (w_hvis && w_vvis) begin
                    {red, green, blue} <= w_pix;
                end else begin
                    {red, green, blue} <= '0;
                end
            end
        end
    end

    // Read strobe FSM; r_rdcnt numbers the cycles of the LOW and RECOVER phases from 1.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_state    <= ST_IDLE;
            r_rdcnt    <= '0;
            r_nef_sync <= 1'b0;
            fifo_nrd   <= 1'b1;
        end else begin
            r_nef_sync <= fifo_nef;
            case (r_state)
                ST_IDLE: begin
                    if (r_nef_sync) begin
                        r_state  <= ST_LOW;
                        r_rdcnt  <= 8'd1;
                        fifo_nrd <= 1'b0;
                    end
                end
                ST_LOW: begin
                    if (r_rdcnt >= 8'(RD_LOW)) begin
                        r_state  <= ST_RECOVER;
                        r_rdcnt  <= 8'd1;
                        fifo_nrd <= 1'b1;
                    end else begin
                        r_rdcnt <= r_rdcnt + 8'd1;
                    end
                end
                ST_RECOVER: begin
                    if (r_rdcnt >= 8'(RD_HIGH)) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_rdcnt <= r_rdcnt + 8'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Commit is listed first so a same-cycle shadow write reaches shadow only.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_pstate   <= PS_CMD;
            r_pidx     <= '0;
            r_red      <= '0;
            r_green    <= '0;
            r_shd_mode <= MODE_SOLID;
            r_act_mode <= MODE_SOLID;
            r_pending  <= 1'b0;
            for (int i = 0; i < NENT; i++) begin
                r_shadow[i] <= '0;
                r_active[i] <= '0;
            end
        end else begin
            if (w_commit) begin
                for (int i = 0; i < NENT; i++) begin
                    r_active[i] <= r_shadow[i];
                end
                r_act_mode <= r_shd_mode;
                r_pending  <= 1'b0;
            end
            if (w_cap) begin
                case (r_pstate)
                    PS_CMD: begin
                        case (fifo_data[7:6])
                            OP_SETPAL: begin
                                r_pidx   <= fifo_data[PAL_BITS-1:0];
                                r_pstate <= PS_RED;
                            end
                            OP_MODE:   r_shd_mode <= mode_e'(fifo_data[1:0]);
                            OP_COMMIT: r_pending  <= 1'b1;
                            OP_RSVD:   ;
                        endcase
                    end
                    PS_RED: begin
                        r_red    <= fifo_data[CW-1:0];
                        r_pstate <= PS_GREEN;
                    end
                    PS_GREEN: begin
                        r_green  <= fifo_data[CW-1:0];
                        r_pstate <= PS_BLUE;
                    end
                    PS_BLUE: begin
                        r_shadow[r_pidx] <= {r_red, r_green, fifo_data[CW-1:0]};
                        r_pstate         <= PS_CMD;
                    end
                    default: r_pstate <= PS_CMD;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_vga_palette_engine.sv
// Directed bench for vga_palette_engine: a small-raster instance for function
// and a default-parameter instance for real line timing.
module tb_vga_palette_engine;

    localparam int SDIV = 2;
    localparam int SHT  = 28;
    localparam int SVT  = 8;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic [7:0] fifo_data = 8'h00;
    logic       fifo_nef = 1'b0;
    logic       fifo_nrd, hsync, vsync;
    logic [3:0] red, green, blue;

    logic [7:0] def_data = 8'h00;
    logic       def_nef = 1'b0;
    logic       def_nrd, def_hsync, def_vsync;
    logic [3:0] def_red, def_green, def_blue;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [7:0] mem [0:255];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int pulses = 0;
    int bad_low = 0;
    int bad_high = 0;
    int low_run = 0;
    int high_run = 100;
    bit prev_nrd = 1'b1;

    always #5 clk = ~clk;

    vga_palette_engine #(
        .CLK_DIV(SDIV), .CW(4), .PAL_BITS(2), .BAR_SHIFT(2),
        .H_VIS(20), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_VIS(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) dut (
        .clk(clk), .nrst(nrst), .fifo_data(fifo_data), .fifo_nef(fifo_nef),
        .fifo_nrd(fifo_nrd), .hsync(hsync), .vsync(vsync),
        .red(red), .green(green), .blue(blue)
    );

    vga_palette_engine dut_def (
        .clk(clk), .nrst(nrst), .fifo_data(def_data), .fifo_nef(def_nef),
        .fifo_nrd(def_nrd), .hsync(def_hsync), .vsync(def_vsync),
        .red(def_red), .green(def_green), .blue(def_blue)
    );

    always @(posedge clk) begin
        if (!nrst) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // FIFO model: a byte is consumed when the read strobe returns high
    always @(negedge clk) begin
        if (fifo_nrd === 1'b0) begin
            if (prev_nrd) begin
                if (high_run < 2) bad_high = bad_high + 1;
                low_run = 0;
            end
            low_run = low_run + 1;
        end else begin
            if (!prev_nrd) begin
                pulses = pulses + 1;
                if (low_run != 6) bad_low = bad_low + 1;
                if (rd_ptr < wr_ptr) rd_ptr = rd_ptr + 1;
                high_run = 0;
            end
            high_run = high_run + 1;
        end
        prev_nrd  = (fifo_nrd === 1'b0) ? 1'b0 : 1'b1;
        fifo_nef  = (rd_ptr < wr_ptr);
        fifo_data = mem[rd_ptr[7:0]];
    end

    task automatic push(input logic [7:0] b);
        mem[wr_ptr[7:0]] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic do_reset();
        nrst = 1'b0;
        wr_ptr = rd_ptr;
        repeat (4) @(negedge clk);
        nrst = 1'b1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(rd_ptr == wr_ptr && fifo_nrd === 1'b1) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 2000) begin
            errors++;
            $display("[TB] FAIL drain_timeout: rd_ptr=%0d required %0d", rd_ptr, wr_ptr);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic goto_pixel(input int h, input int v);
        int p;
        bit found = 1'b0;
        for (int n = 0; n < 2000 && !found; n++) begin
            @(negedge clk);
            if (cyc >= 1) begin
                p = (cyc - 1) / SDIV;
                if ((p % SHT) == h && ((p / SHT) % SVT) == v) found = 1'b1;
            end
        end
        if (!found) begin
            checks++;
            errors++;
            $display("[TB] FAIL goto_pixel: pixel (%0d,%0d) not reached", h, v);
        end
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (fifo_nrd !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_nrd: got %b required 1", fifo_nrd);
        end
        checks++;
        if ({red, green, blue} !== 12'h000) begin
            errors++;
            $display("[TB] FAIL reset_rgb: got %h required 000", {red, green, blue});
        end
        checks++;
        if (hsync !== 1'b0 || vsync !== 1'b0 || def_hsync !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_sync: got h=%b v=%b defh=%b required 0", hsync, vsync, def_hsync);
        end
        nrst = 1'b1;
    endtask

    task automatic test_timing();
        int t1, t2, t3, n;
        do_reset();
        n = 0;
        while (def_hsync !== 1'b1 && n < 4000) begin @(negedge clk); n++; end
        t1 = cyc;
        n = 0;
        while (def_hsync !== 1'b0 && n < 4000) begin @(negedge clk); n++; end
        t2 = cyc;
        n = 0;
        while (def_hsync !== 1'b1 && n < 4000) begin @(negedge clk); n++; end
        t3 = cyc;
        checks++;
        if (t1 != 2521) begin
            errors++;
            $display("[TB] FAIL hsync_start: rise at cycle %0d required 2521 (hcount 840)", t1);
        end
        checks++;
        if (t2 - t1 != 384) begin
            errors++;
            $display("[TB] FAIL hsync_width: %0d clk required 384", t2 - t1);
        end
        checks++;
        if (t3 - t1 != 3168) begin
            errors++;
            $display("[TB] FAIL line_period: %0d clk required 3168", t3 - t1);
        end
    endtask

    task automatic test_sync();
        int th [9] = '{21, 22, 24, 25, 5, 0, 0, 27, 0};
        int tv [9] = '{0, 0, 0, 0, 1, 4, 5, 6, 7};
        bit eh [9] = '{0, 1, 1, 0, 0, 0, 0, 0, 0};
        bit ev [9] = '{0, 0, 0, 0, 0, 0, 1, 1, 0};
        do_reset();
        for (int i = 0; i < 9; i++) begin
            goto_pixel(th[i], tv[i]);
            checks++;
            if (hsync !== eh[i] || vsync !== ev[i] || {red, green, blue} !== 12'h000) begin
                errors++;
                $display("[TB] FAIL sync_decode(%0d,%0d): got h=%b v=%b rgb=%h required h=%b v=%b rgb=000",
                         th[i], tv[i], hsync, vsync, {red, green, blue}, eh[i], ev[i]);
            end
        end
    endtask

    task automatic test_update();
        int p0, bl0, bh0;
        do_reset();
        p0 = pulses; bl0 = bad_low; bh0 = bad_high;
        push(8'h00); push(8'h0F); push(8'h08); push(8'h03); push(8'h80);
        wait_idle();
        checks++;
        if (pulses - p0 != 5 || bad_low != bl0 || bad_high != bh0) begin
            errors++;
            $display("[TB] FAIL nrd_pulses: got %0d pulses, %0d bad low, %0d bad high required 5,0,0",
                     pulses - p0, bad_low - bl0, bad_high - bh0);
        end
        goto_pixel(0, 3);
        checks++;
        if ({red, green, blue} !== 12'h000) begin
            errors++;
            $display("[TB] FAIL pre_commit: got %h required 000", {red, green, blue});
        end
        goto_pixel(0, 0);
        checks++;
        if ({red, green, blue} !== 12'hF83) begin
            errors++;
            $display("[TB] FAIL post_commit: got %h required F83", {red, green, blue});
        end
        goto_pixel(21, 0);
        checks++;
        if ({red, green, blue} !== 12'h000) begin
            errors++;
            $display("[TB] FAIL blanking: got %h required 000", {red, green, blue});
        end
        goto_pixel(19, 3);
        checks++;
        if ({red, green, blue} !== 12'hF83) begin
            errors++;
            $display("[TB] FAIL solid_last: got %h required F83", {red, green, blue});
        end
    endtask

    task automatic test_bars();
        int          bh [8] = '{0, 3, 4, 7, 8, 12, 16, 19};
        int          bv [8] = '{0, 0, 0, 0, 0, 0, 0, 1};
        logic [11:0] be [8] = '{12'h123, 12'h123, 12'h456, 12'h456,
                                12'h789, 12'hABC, 12'h123, 12'h123};
        do_reset();
        push(8'h00); push(8'h01); push(8'h02); push(8'h03);
        push(8'h01); push(8'h04); push(8'h05); push(8'h06);
        push(8'h02); push(8'h07); push(8'h08); push(8'h09);
        push(8'h03); push(8'h0A); push(8'h0B); push(8'h0C);
        push(8'h41); push(8'h80);
        wait_idle();
        for (int i = 0; i < 8; i++) begin
            goto_pixel(bh[i], bv[i]);
            checks++;
            if ({red, green, blue} !== be[i]) begin
                errors++;
                $display("[TB] FAIL hbar(%0d,%0d): got %h required %h", bh[i], bv[i], {red, green, blue}, be[i]);
            end
        end
    endtask

    task automatic test_starve();
        int p0;
        do_reset();
        push(8'h00); push(8'h0A);
        wait_idle();
        p0 = pulses;
        repeat (100) @(negedge clk);
        checks++;
        if (pulses != p0 || fifo_nrd !== 1'b1) begin
            errors++;
            $display("[TB] FAIL starve_idle: got %0d extra pulses nrd=%b required 0 and 1", pulses - p0, fifo_nrd);
        end
        push(8'h0B); push(8'h0C); push(8'hC0); push(8'h80);
        wait_idle();
        goto_pixel(0, 0);
        checks++;
        if ({red, green, blue} !== 12'hABC) begin
            errors++;
            $display("[TB] FAIL starve_resume: got %h required ABC", {red, green, blue});
        end
        goto_pixel(10, 2);
        checks++;
        if ({red, green, blue} !== 12'hABC) begin
            errors++;
            $display("[TB] FAIL starve_mode: got %h required ABC", {red, green, blue});
        end
    endtask

    task automatic test_reset_midread();
        int p0, n;
        do_reset();
        p0 = pulses;
        push(8'h00); push(8'h07);
        n = 0;
        while (!(pulses > p0 && fifo_nrd === 1'b0) && n < 500) begin @(negedge clk); n++; end
        checks++;
        if (fifo_nrd !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midread_setup: nrd=%b required 0", fifo_nrd);
        end
        repeat (2) @(negedge clk);
        nrst = 1'b0;
        @(negedge clk);
        checks++;
        if (fifo_nrd !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midread_release: got %b required 1", fifo_nrd);
        end
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        push(8'h00); push(8'h01); push(8'h02); push(8'h03); push(8'h80);
        wait_idle();
        goto_pixel(0, 0);
        checks++;
        if ({red, green, blue} !== 12'h123) begin
            errors++;
            $display("[TB] FAIL midread_reparse: got %h required 123", {red, green, blue});
        end
    endtask

    initial begin
        $display("[TB] vga_palette_engine directed bench");
        test_reset();
        test_timing();
        test_sync();
        test_update();
        test_bars();
        test_starve();
        test_reset_midread();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
